apb_slave_bridge: RTL and testbench
===================================

Name: apb_slave_bridge

Overview:
Parametrised APB3 slave front-end for the round-robin interconnect. It captures each APB transfer and pushes it as a request (addr/data/strobe/dir) into the downstream request FIFO over a valid/ready handshake. For reads, and for writes when non-posted, it waits for the arbiter's response channel before completing. It adds three things: configurable widths, posted/non-posted writes, and response timeout with error signalling.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; multiple of 8
ADDR_LIMIT, 32'h0000_FFFF, highest legal address; PADDR > ADDR_LIMIT is a decode error
POSTED_WR, 1, 1 = write completes on FIFO accept; 0 = write waits for rsp_valid
TIMEOUT, 64, max WAIT cycles before error; 0 disables timeout

Ports:
PCLK  in  1  clock
PRESET  in  1  reset, synchronous active-high
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write
PADDR  in  ADDR_W  APB address
PWDATA  in  DATA_W  APB write data
PSTRB  in  DATA_W/8  byte strobes
PRDATA  out  DATA_W  read data, valid with PREADY
PREADY  out  1  transfer complete
PSLVERR  out  1  error, valid with PREADY
req_valid  out  1  request to FIFO
req_ready  in  1  FIFO can accept (not full)
req_write  out  1  request direction
req_addr  out  ADDR_W  latched address
req_wdata  out  DATA_W  latched write data
req_strb  out  DATA_W/8  latched strobes (0 for reads)
rsp_valid  in  1  arbiter response strobe, single cycle
rsp_data  in  DATA_W  read data
rsp_err  in  1  downstream error
err_count  out  8  saturating count of PSLVERR completions

Behaviour:
- Reset (PRESET=1 at PCLK edge): state IDLE; PREADY=0, PSLVERR=0, PRDATA=0, req_valid=0, req_* =0, err_count=0, timer=0. Reset mid-transfer drops the request and any pending response.
- All outputs registered; req_* driven from the latch registers.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: on PSEL & !PENABLE (setup), latch PADDR/PWDATA/PSTRB/PWRITE.
  - Address legal -> REQ.
  - PADDR > ADDR_LIMIT -> DONE with err=1. No FIFO push.
- REQ: req_valid=1, held stable until req_ready.
  - On handshake, write with POSTED_WR=1 -> DONE, err=0.
  - On handshake, otherwise -> WAIT, timer cleared.
- WAIT: timer increments each cycle.
  - rsp_valid -> DONE; capture rsp_data (reads only) and err=rsp_err.
  - TIMEOUT!=0 and timer==TIMEOUT-1 without rsp_valid -> DONE, err=1, PRDATA=0.
  - rsp_valid and timeout in the same cycle: response wins.
- DONE: PREADY=1 for exactly one cycle, with PSLVERR=err and PRDATA (reads). Then IDLE.
  - err_count increments when err=1, saturates at 255.
- Minimum latency: setup at T0, REQ at T1 (req_ready=1), PREADY at T2 for posted write or decode error. Reads: PREADY one cycle after rsp_valid.
- PREADY stays 0 in every state except DONE. PSLVERR and PRDATA are 0 whenever PREADY=0.
- Late response: rsp_valid in IDLE/REQ/DONE after a timeout is discarded, one per timed-out request.
  - Tracked by a 1-bit stale flag. While stale=1, the next rsp_valid is consumed silently.
- PSEL dropped before PREADY (master protocol violation):
  - In REQ, the request is still pushed.
  - In WAIT, go to DRAIN: wait for rsp_valid or timeout, no PREADY pulse, then IDLE.
- A new setup is not sampled until the state returns to IDLE.

Decomposition:
- Package apb_ic_pkg:
  - state enum apb_br_state_e {IDLE,REQ,WAIT,DONE,DRAIN}
  - packed struct apb_req_t {write, addr, wdata, strb}, parametrised via localparams
  - ERR_CNT_W=8
- One sub-module: apb_rsp_timer. Counts in WAIT/DRAIN, clear/enable inputs, expired output, width $clog2(TIMEOUT+1). Tied off when TIMEOUT=0.

Test Plan:
- Posted write, POSTED_WR=1, req_ready=1: PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=0xF -> req_valid at T1 with matching fields; PREADY=1, PSLVERR=0 at T2.
- Read with rsp_valid 5 cycles after push, rsp_data=0xA5A5_0001 -> PRDATA=0xA5A5_0001, PREADY one cycle after rsp_valid, PREADY low before.
- Decode error, PADDR=0x0001_0000 -> no req_valid, PREADY=PSLVERR=1 at T2, err_count=1.
- Backpressure, req_ready=0 for 10 cycles -> req_valid and req fields stable throughout, PREADY=0; completes after req_ready=1.
- Timeout, TIMEOUT=8, no response -> PSLVERR at WAIT+8; later rsp_valid discarded; next read completes with its own data.
- Non-posted write (POSTED_WR=0) with rsp_err=1 -> PSLVERR=1. Then assert PRESET during WAIT of a read -> all outputs 0 next cycle, err_count=0.

Source files
------------

// File: rtl/apb_ic_pkg.sv
// Shared types and constants for the APB slave bridge of the round-robin interconnect.
package apb_ic_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;
  localparam int unsigned ERR_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } apb_br_state_e;

  // Request payload as pushed into the downstream request FIFO
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_req_t;

  // Saturating increment for the error counter
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/apb_rsp_timer.sv
// Response watchdog: counts cycles spent waiting for the arbiter response.
module apb_rsp_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt;

  // Wait-cycle counter; held at zero when the watchdog is disabled
  always_ff @(posedge PCLK) begin
    if (PRESET || clr || (TIMEOUT == 0)) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Fires during the last permitted wait cycle; tied low when TIMEOUT is 0
  assign expired_c = (TIMEOUT != 0) && en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_slave_bridge.sv
// APB3 slave front-end: turns each APB transfer into a FIFO request and waits for the response.
module apb_slave_bridge
  import apb_ic_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0000_FFFF),
  parameter bit                POSTED_WR  = 1'b1,
  parameter int unsigned       TIMEOUT    = 64
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_W-1:0]     req_addr,
  output logic [DATA_W-1:0]     req_wdata,
  output logic [DATA_W/8-1:0]   req_strb,
  input  logic                  rsp_valid,
  input  logic [DATA_W-1:0]     rsp_data,
  input  logic                  rsp_err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  apb_br_state_e state;
  logic          stale;      // one timed-out response still owed by the arbiter
  logic          dec_err;    // current transfer failed address decode
  logic          timer_en;
  logic          timer_clr;
  logic          timer_expired;
  logic          fresh_rsp;
  logic          wait_err;

  assign timer_en  = (state == WAIT) || (state == DRAIN);
  assign timer_clr = (state == REQ);
  assign fresh_rsp = rsp_valid && !stale;
  assign wait_err  = fresh_rsp ? rsp_err : 1'b1;

  apb_rsp_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_rsp_timer (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .clr       (timer_clr),
    .en        (timer_en),
    .expired_c (timer_expired)
  );

  // Transfer sequencer with registered APB and request outputs
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      stale     <= 1'b0;
      dec_err   <= 1'b0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_strb  <= '0;
      err_count <= '0;
    end else begin
      // A late response for an abandoned request is swallowed wherever it lands
      if (rsp_valid && stale) begin
        stale <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            req_write <= PWRITE;
            req_addr  <= PADDR;
            req_wdata <= PWDATA;
            req_strb  <= PWRITE ? PSTRB : '0;
            state     <= REQ;
            // Decode errors pass through REQ without a push so they complete one cycle later
            if (PADDR > ADDR_LIMIT) begin
              dec_err <= 1'b1;
            end else begin
              dec_err   <= 1'b0;
              req_valid <= 1'b1;
            end
          end
        end

        REQ: begin
          if (dec_err) begin
            state     <= DONE;
            PREADY    <= 1'b1;
            PSLVERR   <= 1'b1;
            err_count <= sat_inc(err_count);
          end else if (req_ready) begin
            req_valid <= 1'b0;
            if (req_write && POSTED_WR) begin
              state  <= DONE;
              PREADY <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (fresh_rsp || timer_expired) begin
            if (!fresh_rsp) begin
              stale <= 1'b1;
            end
            if (PSEL) begin
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= wait_err;
              PRDATA  <= (fresh_rsp && !req_write) ? rsp_data : '0;
              if (wait_err) begin
                err_count <= sat_inc(err_count);
              end
            end else begin
              state <= IDLE;
            end
          end else if (!PSEL) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          if (fresh_rsp || timer_expired) begin
            state <= IDLE;
            if (!fresh_rsp) begin
              stale <= 1'b1;
            end
          end
        end

        DONE: begin
          state   <= IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_bridge.sv
// Self-checking bench for apb_slave_bridge: table vectors, random transfers, directed corner cases.
module tb_apb_slave_bridge;

  localparam int unsigned TO = 8;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  logic [31:0] PRDATA, b_PRDATA;
  logic        PREADY, PSLVERR, b_PREADY, b_PSLVERR;
  logic        req_valid, req_write, b_req_valid, b_req_write;
  logic [31:0] req_addr, req_wdata, b_req_addr, b_req_wdata;
  logic [3:0]  req_strb, b_req_strb;
  logic [7:0]  err_count, b_err_count;

  apb_slave_bridge #(.ADDR_W(32), .DATA_W(32), .ADDR_LIMIT(32'h0000_FFFF),
                     .POSTED_WR(1'b1), .TIMEOUT(TO)) dut_posted (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .err_count(err_count));

  apb_slave_bridge #(.ADDR_W(32), .DATA_W(32), .ADDR_LIMIT(32'h0000_FFFF),
                     .POSTED_WR(1'b0), .TIMEOUT(TO)) dut_nonposted (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(b_PRDATA), .PREADY(b_PREADY),
    .PSLVERR(b_PSLVERR), .req_valid(b_req_valid), .req_ready(req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_strb(b_req_strb), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .err_count(b_err_count));

  always #5 PCLK = ~PCLK;

  // One APB transfer: rd = cycles of req_ready low in REQ, d = response offset into WAIT
  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          rd;
    int          d;
    logic [31:0] rdat;
    bit          rerr;
  } xfer_t;

  // Expected outcome: lat = cycle of PREADY counted from the setup cycle
  typedef struct {
    int          lat;
    bit          err;
    logic [31:0] prdata;
    bit          push;
  } exp_t;

  typedef struct {
    xfer_t x;
    exp_t  e;
    int    ecnt;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  string cur_tag = "reset";

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s @%0t: got 0x%0h, expected 0x%0h", cur_tag, name, $time, act, exp);
    end
  endtask

  // Transaction-level reference for the posted instance (legal range 0..0xFFFF)
  function automatic exp_t model(input xfer_t x);
    exp_t e;
    e.push = (x.addr <= 32'h0000_FFFF);
    if (!e.push) begin
      e.lat = 2; e.err = 1'b1; e.prdata = '0;
    end else if (x.write) begin
      e.lat = x.rd + 2; e.err = 1'b0; e.prdata = '0;
    end else if (x.d < int'(TO)) begin
      e.lat = x.rd + 3 + x.d; e.err = x.rerr; e.prdata = x.rdat;
    end else begin
      e.lat = x.rd + 2 + int'(TO); e.err = 1'b1; e.prdata = '0;
    end
    return e;
  endfunction

  // Drive one transfer on the posted instance and check every cycle, plus one idle cycle after
  task automatic run_xfer(input xfer_t x, input exp_t e, input int ecnt);
    int h;
    bit need_rsp;
    bit in_req;
    h = 1 + x.rd;
    need_rsp = e.push && !x.write;
    for (int c = 0; c <= e.lat + 1; c++) begin
      @(negedge PCLK);
      in_req = e.push && (c >= 1) && (c <= h);
      chk("pready", PREADY, c == e.lat);
      if (c == e.lat) chk("pslverr_prdata", {PSLVERR, PRDATA}, {e.err, e.prdata});
      else            chk("resp_zero", {PSLVERR, PRDATA}, 33'b0);
      chk("req_valid", req_valid, in_req);
      if (in_req)
        chk("req_fields", {req_write, req_addr, req_wdata, req_strb},
            {x.write, x.addr, x.wdata, (x.write ? x.strb : 4'h0)});
      if (c == e.lat + 1) chk("err_count", err_count, 8'(ecnt));
      PSEL    = (c <= e.lat);
      PENABLE = (c >= 1) && (c <= e.lat);
      if (c == 0) begin
        PWRITE = x.write; PADDR = x.addr; PWDATA = x.wdata; PSTRB = x.strb;
      end
      req_ready = (c >= h);
      rsp_valid = need_rsp && (c == h + 1 + x.d);
      rsp_data  = rsp_valid ? x.rdat : $urandom();
      rsp_err   = rsp_valid ? x.rerr : 1'($urandom());
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_err = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("reset_outs", {PREADY, PSLVERR, PRDATA, req_valid, req_write, req_addr, req_wdata, req_strb}, '0);
    chk("reset_err_count", {err_count, b_err_count}, 16'h0);
    PRESET = 1'b0;
  endtask

  vec_t  vecs[10];
  xfer_t rx;
  exp_t  re;
  int    ecnt;

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = '0;

    //             write  addr           wdata          strb  rd  d  rdat           rerr     lat err prdata        push   ecnt
    vecs[0] = '{'{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0,  0, 32'h0,         1'b0}, '{2,  1'b0, 32'h0,         1'b1}, 0};
    vecs[1] = '{'{1'b0, 32'h0000_0020, 32'h0000_1111, 4'hF, 0,  4, 32'hA5A5_0001, 1'b0}, '{7,  1'b0, 32'hA5A5_0001, 1'b1}, 0};
    vecs[2] = '{'{1'b1, 32'h0001_0000, 32'h0000_0022, 4'hF, 0,  0, 32'h0,         1'b0}, '{2,  1'b1, 32'h0,         1'b0}, 1};
    vecs[3] = '{'{1'b1, 32'h0000_0040, 32'h3333_3333, 4'h5, 10, 0, 32'h0,         1'b0}, '{12, 1'b0, 32'h0,         1'b1}, 1};
    vecs[4] = '{'{1'b0, 32'h0000_0044, 32'h0,         4'hF, 0,  9, 32'hBAD0_BAD0, 1'b0}, '{10, 1'b1, 32'h0,         1'b1}, 2};
    vecs[5] = '{'{1'b0, 32'h0000_0048, 32'h0,         4'hF, 1,  0, 32'h1234_5678, 1'b0}, '{4,  1'b0, 32'h1234_5678, 1'b1}, 2};
    vecs[6] = '{'{1'b0, 32'h0000_004C, 32'h0,         4'hF, 0,  7, 32'hCAFE_F00D, 1'b1}, '{10, 1'b1, 32'hCAFE_F00D, 1'b1}, 3};
    vecs[7] = '{'{1'b0, 32'h0000_0050, 32'h0,         4'hF, 2,  8, 32'hDEAD_0008, 1'b0}, '{12, 1'b1, 32'h0,         1'b1}, 4};
    vecs[8] = '{'{1'b0, 32'h0000_FFFF, 32'h0,         4'hF, 0,  1, 32'h600D_F00D, 1'b0}, '{4,  1'b0, 32'h600D_F00D, 1'b1}, 4};
    vecs[9] = '{'{1'b1, 32'hFFFF_FFFF, 32'h0,         4'hF, 0,  0, 32'h0,         1'b0}, '{2,  1'b1, 32'h0,         1'b0}, 5};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_xfer(vecs[i].x, vecs[i].e, vecs[i].ecnt);
    end

    // Random transfers against the transaction model; every timeout gets a late response
    ecnt = 5;
    for (int i = 0; i < 60; i++) begin
      cur_tag  = $sformatf("rand%0d", i);
      rx.write = 1'($urandom_range(0, 1));
      rx.addr  = ($urandom_range(0, 5) == 0) ? (32'h0001_0000 + 32'($urandom_range(0, 4096)))
                                             : 32'($urandom_range(0, 16'hFFFF));
      rx.wdata = $urandom();
      rx.strb  = 4'($urandom_range(0, 15));
      rx.rd    = $urandom_range(0, 3);
      rx.d     = $urandom_range(0, 9);
      rx.rdat  = $urandom();
      rx.rerr  = ($urandom_range(0, 3) == 0);
      re = model(rx);
      if (re.err && ecnt < 255) ecnt++;
      run_xfer(rx, re, ecnt);
    end

    // Non-posted write with downstream error on the second instance
    cur_tag = "nonposted";
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge PCLK);
      chk("np_pready", b_PREADY, c == 4);
      chk("posted_pready", PREADY, c == 2);
      if (c == 4) chk("np_pslverr", b_PSLVERR, 1'b1);
      if (c == 1) chk("np_req", {b_req_valid, b_req_write, b_req_addr, b_req_strb},
                      {1'b1, 1'b1, 32'h0000_0080, 4'h3});
      if (c == 5) chk("np_err_count", {b_err_count, err_count}, {8'd1, 8'd0});
      PSEL = (c <= 4); PENABLE = (c >= 1) && (c <= 4);
      if (c == 0) begin PWRITE = 1'b1; PADDR = 32'h80; PWDATA = 32'h5555_AAAA; PSTRB = 4'h3; end
      req_ready = 1'b1;
      rsp_valid = (c == 3); rsp_err = (c == 3); rsp_data = 32'h0;
    end

    // Give the posted instance a nonzero error count, then reset in the middle of a read
    cur_tag = "pre_reset_dec";
    rx = '{1'b1, 32'h0002_0000, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0};
    run_xfer(rx, model(rx), 1);
    cur_tag = "reset_in_wait";
    for (int c = 0; c <= 4; c++) begin
      @(negedge PCLK);
      if (c == 3) chk("wait_quiet", {PREADY, req_valid, err_count}, {2'b00, 8'd1});
      if (c == 4) begin
        chk("rst_outs", {PREADY, PSLVERR, PRDATA, req_valid, req_write, req_addr, req_wdata, req_strb}, '0);
        chk("rst_err_count", {err_count, b_err_count}, 16'h0);
      end
      PSEL = (c <= 3); PENABLE = (c >= 1) && (c <= 3);
      if (c == 0) begin PWRITE = 1'b0; PADDR = 32'h90; PWDATA = 32'h0; PSTRB = 4'h0; end
      req_ready = 1'b1; rsp_valid = 1'b0;
      PRESET = (c == 3);
    end
    cur_tag = "after_reset";
    rx = '{1'b0, 32'h0000_0094, 32'h0, 4'h0, 0, 2, 32'h0BAD_CAFE, 1'b0};
    run_xfer(rx, model(rx), 0);

    // Master drops PSEL during WAIT: no completion, response drained silently
    cur_tag = "drain";
    for (int c = 0; c <= 8; c++) begin
      @(negedge PCLK);
      chk("drain_no_pready", PREADY, 1'b0);
      if (c == 8) chk("drain_err_count", err_count, 8'd0);
      PSEL = (c <= 1); PENABLE = (c == 1);
      if (c == 0) begin PWRITE = 1'b0; PADDR = 32'hA0; PWDATA = 32'h0; PSTRB = 4'h0; end
      req_ready = 1'b1;
      rsp_valid = (c == 4); rsp_data = 32'hFEED_0000; rsp_err = 1'b0;
    end
    cur_tag = "after_drain";
    rx = '{1'b0, 32'h0000_00A4, 32'h0, 4'h0, 1, 3, 32'h7777_1234, 1'b0};
    run_xfer(rx, model(rx), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
